// File: rtl/ctrl_seq.sv
// Microcoded T-stage sequencer for the 8-bit bus CPU: fetch over the shared bus, one-hot control word, PC.
// Optional single-step gating in T0 is built when CTRL_SEQ_STEP_EN is defined (adds the i_step port).
module ctrl_seq #(
  parameter int PC_W   = 4,
  parameter int CTRL_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [7:0]        i_bus,
`ifdef CTRL_SEQ_STEP_EN
  input  logic              i_step,
`endif
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [PC_W-1:0]   o_pc,
  output logic [2:0]        o_stage,
  output logic              o_halted,
  output logic              o_bad_op
);

  localparam logic [2:0] ST_T0   = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd7;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [CTRL_W-1:0] C_AI  = CTRL_W'(1) << 0;
  localparam logic [CTRL_W-1:0] C_AO  = CTRL_W'(1) << 1;
  localparam logic [CTRL_W-1:0] C_II  = CTRL_W'(1) << 2;
  localparam logic [CTRL_W-1:0] C_IO  = CTRL_W'(1) << 3;
  localparam logic [CTRL_W-1:0] C_IIO = CTRL_W'(1) << 4;
  localparam logic [CTRL_W-1:0] C_OI  = CTRL_W'(1) << 5;
  localparam logic [CTRL_W-1:0] C_MO  = CTRL_W'(1) << 8;

  // Control word for the first execute stage, decoded from the opcode arriving on the bus.
  function automatic logic [CTRL_W-1:0] f_exec1(input logic [3:0] op);
    case (op)
      OP_LDA:  f_exec1 = C_AI | C_IO | C_IIO;
      OP_OUT:  f_exec1 = C_AO | C_OI;
      default: f_exec1 = '0;
    endcase
  endfunction

  function automatic logic f_undef(input logic [3:0] op);
    f_undef = !(op inside {OP_NOP, OP_LDA, OP_JMP, OP_OUT, OP_HLT});
  endfunction

  logic [2:0]        r_stage;
  logic [7:0]        r_instr;
  logic [PC_W-1:0]   r_pc;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_bad_op;

  logic [2:0]        w_stage_nx;
  logic [7:0]        w_instr_nx;
  logic [PC_W-1:0]   w_pc_nx;
  logic [CTRL_W-1:0] w_ctrl_nx;
  logic              w_bad_nx;
  logic              w_go;

`ifdef CTRL_SEQ_STEP_EN
  assign w_go = i_en & i_step;
`else
  assign w_go = i_en;
`endif

  // o_ctrl/o_bad_op are loaded from the decode of the next stage so they hold for the whole stage.
  always_comb begin
    w_stage_nx = r_stage;
    w_instr_nx = r_instr;
    w_pc_nx    = r_pc;
    w_ctrl_nx  = '0;
    w_bad_nx   = 1'b0;
    case (r_stage)
      ST_T0: begin
        if (w_go) begin
          w_stage_nx = ST_T1;
          w_ctrl_nx  = C_MO | C_II;
        end
      end
      ST_T1: begin
        w_stage_nx = ST_T2;
        w_instr_nx = i_bus;
        w_pc_nx    = r_pc + PC_W'(1);
        w_ctrl_nx  = f_exec1(i_bus[7:4]);
        w_bad_nx   = f_undef(i_bus[7:4]);
      end
      ST_T2: begin
        case (r_instr[7:4])
          OP_LDA, OP_OUT: w_stage_nx = ST_T3;
          OP_HLT:         w_stage_nx = ST_HALT;
          OP_JMP: begin
            w_stage_nx = ST_T0;
            w_pc_nx    = PC_W'(r_instr[3:0]);
          end
          default:        w_stage_nx = ST_T0;
        endcase
      end
      ST_T3:   w_stage_nx = ST_T0;
      ST_HALT: w_stage_nx = ST_HALT;
      default: w_stage_nx = ST_T0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_stage  <= ST_T0;
      r_instr  <= '0;
      r_pc     <= '0;
      r_ctrl   <= '0;
      r_bad_op <= 1'b0;
    end else begin
      r_stage  <= w_stage_nx;
      r_instr  <= w_instr_nx;
      r_pc     <= w_pc_nx;
      r_ctrl   <= w_ctrl_nx;
      r_bad_op <= w_bad_nx;
    end
  end

  assign o_ctrl   = r_ctrl;
  assign o_pc     = r_pc;
  assign o_stage  = r_stage;
  assign o_halted = (r_stage == ST_HALT);
  assign o_bad_op = r_bad_op;

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Microcoded control sequencer for the 8-bit bus CPU. It fetches each instruction from ROM over the shared bus and steps through the T-stages. Every cycle it drives the 16-bit one-hot control word consumed by the A register, instruction register, output register and ROM, and it owns the program counter. It replaces the inline stage/opcode decode in the CPU top level, which then only instantiates the datapath and this block.

## Interface
Parameters:
- PC_W, 4, program counter width; ROM depth is 2^PC_W.
- CTRL_W, 16, control word width; bits 9..CTRL_W-1 are always 0.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst  in  1  reset, synchronous, active-low.
- i_en  in  1  run enable; sampled only in T0.
- i_bus  in  8  shared data bus; sampled at end of T1.
- o_ctrl  out  CTRL_W  registered control word. AI=0, AO=1, II=2, IO=3, IIO=4, OI=5, OO=6, MI=7, MO=8.
- o_pc  out  PC_W  program counter, ROM address.
- o_stage  out  3  current stage: T0=0, T1=1, T2=2, T3=3, HALT=7.
- o_halted  out  1  high while in HALT.
- o_bad_op  out  1  one-cycle pulse in T2 on an undefined opcode.
- i_step  in  1  single-step strobe; present only with CTRL_SEQ_STEP_EN.

## Operation
- Internal instruction latch: opcode = instr[7:4], imm = instr[3:0].
- Opcodes: NOP=0000, LDA=0001, JMP=0110, OUT=1110, HLT=1111. All others are undefined.
- T0 (gate): o_ctrl=0.
  - i_en=1 → T1.
  - i_en=0 → stay in T0.
- T1 (fetch): o_ctrl = MO|II.
  - End of cycle: instr <= i_bus; pc <= pc+1, wrapping from 2^PC_W-1 to 0.
  - Next: T2.
- T2 (execute 1):
  - NOP: o_ctrl=0 → T0.
  - LDA: o_ctrl = AI|IO|IIO → T3.
  - OUT: o_ctrl = AO|OI → T3.
  - JMP: o_ctrl=0; pc <= imm zero-extended to PC_W; overrides the T1 increment → T0.
  - HLT: o_ctrl=0 → HALT.
  - Undefined: o_ctrl=0, o_bad_op=1 for this cycle only → T0 (treated as NOP).
- T3 (execute 2): o_ctrl=0 (bus settle/recovery) → T0.
- HALT: o_ctrl=0, o_halted=1. Leaves HALT only on reset; i_en and i_step are ignored.
- Bus-driver invariant: at most one of AO, IO, MO, OO is set in any cycle.

## Timing
- Reset (i_rst=0 at a rising edge): on the next cycle o_ctrl=0, o_pc=0, o_stage=0, o_halted=0, o_bad_op=0, instr=0.
- Reset mid-instruction: abandons the instruction immediately; no partial control word survives.
- o_ctrl is registered, loaded from the decode of the next state, so its value is valid for the whole cycle the stage occupies.
- The ROM must present data on i_bus within the T1 cycle.
- Instruction latency, counted from T0 with i_en=1: NOP/JMP/undefined = 3 cycles; LDA/OUT = 4 cycles; HLT = 3 cycles to reach HALT.
- i_en low in T0: the sequencer idles indefinitely with o_ctrl=0 and pc held. An instruction already past T0 always completes.
- JMP at pc=2^PC_W-1: the jump target wins over the wrap.

## Configuration
- CTRL_SEQ_STEP_EN defined:
  - i_step port exists.
  - T0 advances only when i_en=1 and i_step=1 in the same cycle, giving exactly one instruction per strobe.
  - A strobe held high runs freely.
  - i_step outside T0 is ignored.
- Not defined: no i_step port; T0 advances on i_en alone.

## Test plan
- Reset then i_en=1, ROM {0x00 NOP, 0xF0 HLT} → o_ctrl sequence 0, 0x104, 0, 0, 0x104, 0. o_halted=1 at cycle 6; pc=2; state stays HALT for 20 further cycles.
- ROM {0x15 LDA 5, 0xE0 OUT, 0xF0} → T2 of LDA shows o_ctrl=0x019, T2 of OUT shows o_ctrl=0x022. The downstream output register captures 0x05.
- ROM[0]=0x63 (JMP 3), ROM[3]=0xF0 → pc sequence 0,1,3,4. JMP takes 3 cycles; halts at pc=4. Also place JMP 2 at address 15: pc goes to 2, not 0.
- Undefined opcode 0x70 → o_bad_op high for exactly one cycle in T2, o_ctrl=0 throughout, next instruction fetched 3 cycles after T0.
- i_rst=0 asserted during T2 of LDA → next cycle o_ctrl=0, pc=0, stage=0. Hold i_en=0 for 5 cycles → stays in T0 with o_ctrl=0. Throughout all tests, assert at most one of AO/IO/MO/OO is set.
- With CTRL_SEQ_STEP_EN, i_en=1: three single-cycle i_step pulses 10 cycles apart → exactly three instructions are fetched (pc 0→3), and the sequencer idles in T0 between pulses.
